// File: rtl/frame_engine_pkg.sv
// Shared types for frame_engine: mode codes, FSM state encoding and address-width helpers.
// Address widths derive from the source geometry; the destination may be up to 4x the source.
package frame_engine_pkg;

  typedef enum logic [1:0] {
    MODE_COPY = 2'b00,
    MODE_UP   = 2'b01,
    MODE_AVG  = 2'b10,
    MODE_DEC  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE,
    ST_WAIT_LOW
  } state_e;

  localparam int SRC_W_DEF = 160;
  localparam int SRC_H_DEF = 120;
  localparam int PIX_W_DEF = 8;

  function automatic int src_aw(input int w, input int h);
    return $clog2(w * h);
  endfunction

  function automatic int dst_aw(input int w, input int h);
    return $clog2(4 * w * h);
  endfunction

  localparam int SRC_AW_DEF = src_aw(SRC_W_DEF, SRC_H_DEF);
  localparam int DST_AW_DEF = dst_aw(SRC_W_DEF, SRC_H_DEF);

endpackage

// File: rtl/frame_engine_if.sv
// Control handshake plus source-read / destination-write ports of frame_engine.
// master = control unit and frame memories, slave = the engine.
interface frame_engine_if
  import frame_engine_pkg::*;
#(
  parameter int SRC_W = SRC_W_DEF,
  parameter int SRC_H = SRC_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) ();

  localparam int SAW = src_aw(SRC_W, SRC_H);
  localparam int DAW = dst_aw(SRC_W, SRC_H);

  logic             start_alu;
  logic [1:0]       mode;
  logic             alu_done;
  logic             busy;
  logic [SAW-1:0]   src_addr;
  logic [PIX_W-1:0] src_data;
  logic [DAW-1:0]   dst_addr;
  logic [PIX_W-1:0] dst_data;
  logic             dst_we;

  modport master (
    output start_alu, mode, src_data,
    input  alu_done, busy, src_addr, dst_addr, dst_data, dst_we
  );

  modport slave (
    input  start_alu, mode, src_data,
    output alu_done, busy, src_addr, dst_addr, dst_data, dst_we
  );

endinterface

// File: rtl/frame_addr_gen.sv
// dx/dy scan counters, sub-pixel read index and src/dst address mapping for frame_engine.
// FRAME_ENGINE_AVG_EN adds the 2-bit sub-pixel index used by the 4-read block average.
module frame_addr_gen
  import frame_engine_pkg::*;
#(
  parameter int SRC_W = SRC_W_DEF,
  parameter int SRC_H = SRC_H_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_i,
  input  logic                          sub_adv_i,
  input  logic                          pix_adv_i,
  input  mode_e                         mode_i,
  output logic [src_aw(SRC_W,SRC_H)-1:0] src_addr_o,
  output logic [dst_aw(SRC_W,SRC_H)-1:0] dst_addr_o,
  output logic [1:0]                    sub_o,
  output logic                          last_sub_o,
  output logic                          last_pix_o
);

  localparam int SAW = src_aw(SRC_W, SRC_H);
  localparam int DAW = dst_aw(SRC_W, SRC_H);
  localparam int XW  = $clog2(2 * SRC_W);
  localparam int YW  = $clog2(2 * SRC_H);

  logic [XW-1:0] dx_q, dx_d;
  logic [YW-1:0] dy_q, dy_d;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  int            dst_w, dst_h;

`ifdef FRAME_ENGINE_AVG_EN
  logic [1:0] sub_q, sub_d;
`else
  logic       unused_sub_adv;
`endif

  always_comb begin
    dst_w = SRC_W / 2;
    dst_h = SRC_H / 2;
    sx    = dx_q << 1;
    sy    = dy_q << 1;
    case (mode_i)
      MODE_COPY: begin
        dst_w = SRC_W;
        dst_h = SRC_H;
        sx    = dx_q;
        sy    = dy_q;
      end
      MODE_UP: begin
        dst_w = 2 * SRC_W;
        dst_h = 2 * SRC_H;
        sx    = dx_q >> 1;
        sy    = dy_q >> 1;
      end
`ifdef FRAME_ENGINE_AVG_EN
      // sub[0] picks the right column, sub[1] the lower row of the 2x2 block
      MODE_AVG: begin
        sx = (dx_q << 1) | XW'(sub_q[0]);
        sy = (dy_q << 1) | YW'(sub_q[1]);
      end
`endif
      default: ;
    endcase
  end

  assign src_addr_o = SAW'(int'(sy) * SRC_W + int'(sx));
  assign dst_addr_o = DAW'(int'(dy_q) * dst_w + int'(dx_q));
  assign last_pix_o = (int'(dx_q) == dst_w - 1) && (int'(dy_q) == dst_h - 1);

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clr_i) begin
      dx_d = '0;
      dy_d = '0;
    end else if (pix_adv_i) begin
      if (int'(dx_q) == dst_w - 1) begin
        dx_d = '0;
        dy_d = dy_q + YW'(1);
      end else begin
        dx_d = dx_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

`ifdef FRAME_ENGINE_AVG_EN
  always_comb begin
    sub_d = sub_q;
    if (clr_i || pix_adv_i) begin
      sub_d = 2'd0;
    end else if (sub_adv_i) begin
      sub_d = sub_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 2'd0;
    end else begin
      sub_q <= sub_d;
    end
  end

  assign sub_o      = sub_q;
  assign last_sub_o = (mode_i != MODE_AVG) || (sub_q == 2'd3);
`else
  assign unused_sub_adv = sub_adv_i;
  assign sub_o          = 2'd0;
  assign last_sub_o     = 1'b1;
`endif

endmodule

// File: rtl/frame_engine.sv
// frame_engine: one copy/upscale/downscale pass per start_alu request, answered by a 1-cycle alu_done.
// FRAME_ENGINE_AVG_EN enables true 2x2 block averaging for mode 10; without it mode 10 decimates.
module frame_engine
  import frame_engine_pkg::*;
#(
  parameter int SRC_W = SRC_W_DEF,
  parameter int SRC_H = SRC_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  frame_engine_if.slave bus
);

  localparam int SAW = src_aw(SRC_W, SRC_H);
  localparam int DAW = dst_aw(SRC_W, SRC_H);
`ifdef FRAME_ENGINE_AVG_EN
  localparam int ACW = PIX_W + 2;
`else
  localparam int ACW = PIX_W;
`endif

  state_e         state_q, state_d;
  mode_e          mode_q, mode_d;
  logic [ACW-1:0] acc_q, acc_d;

  logic           clr, sub_adv, pix_adv, capture;
  logic           last_sub, last_pix;
  logic [1:0]     sub;
  logic [SAW-1:0] src_addr;
  logic [DAW-1:0] dst_addr;

  frame_addr_gen #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .sub_adv_i  (sub_adv),
    .pix_adv_i  (pix_adv),
    .mode_i     (mode_q),
    .src_addr_o (src_addr),
    .dst_addr_o (dst_addr),
    .sub_o      (sub),
    .last_sub_o (last_sub),
    .last_pix_o (last_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COPY;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    clr     = 1'b0;
    sub_adv = 1'b0;
    pix_adv = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_alu) begin
          state_d = ST_FETCH;
          clr     = 1'b1;
`ifdef FRAME_ENGINE_AVG_EN
          mode_d  = mode_e'(bus.mode);
`else
          mode_d  = (bus.mode == MODE_AVG) ? MODE_DEC : mode_e'(bus.mode);
`endif
        end
      end
      ST_FETCH: begin
        state_d = bus.start_alu ? ST_CAPTURE : ST_IDLE;
      end
      ST_CAPTURE: begin
        if (!bus.start_alu) begin
          state_d = ST_IDLE;
        end else begin
          capture = 1'b1;
          if (last_sub) begin
            state_d = ST_WRITE;
          end else begin
            sub_adv = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_WRITE: begin
        if (!bus.start_alu) begin
          state_d = ST_IDLE;
        end else if (last_pix) begin
          state_d = ST_DONE;
        end else begin
          pix_adv = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE:     state_d = ST_WAIT_LOW;
      // start_alu is still high here; wait for it to drop before re-arming
      ST_WAIT_LOW: if (!bus.start_alu) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

`ifdef FRAME_ENGINE_AVG_EN
  always_comb begin
    acc_d = acc_q;
    if (capture) begin
      acc_d = (sub == 2'd0) ? ACW'(bus.src_data) : acc_q + ACW'(bus.src_data);
    end
  end

  assign bus.dst_data = (mode_q == MODE_AVG) ? acc_q[PIX_W+1:2] : acc_q[PIX_W-1:0];
`else
  logic unused_sub;
  assign unused_sub = ^sub;

  always_comb begin
    acc_d = acc_q;
    if (capture) begin
      acc_d = bus.src_data;
    end
  end

  assign bus.dst_data = acc_q;
`endif

  assign bus.alu_done = (state_q == ST_DONE);
  assign bus.busy     = (state_q == ST_FETCH) || (state_q == ST_CAPTURE) ||
                        (state_q == ST_WRITE) || (state_q == ST_DONE);
  assign bus.dst_we   = (state_q == ST_WRITE);
  assign bus.src_addr = src_addr;
  assign bus.dst_addr = dst_addr;

endmodule

// File: tb/tb_frame_engine.sv
// Scoreboard bench for frame_engine on a 4x2 source whose pixel at address a holds a+10.
module tb_frame_engine;
  import frame_engine_pkg::*;

  localparam int SW = 4;
  localparam int SH = 2;
  localparam int PW = 8;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  frame_engine_if #(.SRC_W(SW), .SRC_H(SH), .PIX_W(PW)) bus ();

  frame_engine #(.SRC_W(SW), .SRC_H(SH), .PIX_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // synchronous read-only source memory
  always @(posedge clk) bus.src_data <= PW'(int'(bus.src_addr) + 10);

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  edge_cnt = 0;
  int  wr_cnt   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.dst_we === 1'b1) begin
      wr_t e;
      wr_cnt++;
      if (sb.size() == 0) begin
        check_eq("extra_write_addr", 32'(bus.dst_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_eq("dst_addr", 32'(bus.dst_addr), e.addr);
        check_eq("dst_data", 32'(bus.dst_data), e.data);
      end
    end
  end

  function automatic int src_px(input int x, input int y);
    return y * SW + x + 10;
  endfunction

  task automatic push_expected(input logic [1:0] m, output int n);
    int dw, dh, v;
    logic [1:0] em;
    wr_t e;
    em = m;
`ifndef FRAME_ENGINE_AVG_EN
    if (m == 2'b10) em = 2'b11;
`endif
    case (em)
      2'b00:   begin dw = SW;     dh = SH;     end
      2'b01:   begin dw = 2 * SW; dh = 2 * SH; end
      default: begin dw = SW / 2; dh = SH / 2; end
    endcase
    n = 0;
    for (int y = 0; y < dh; y++) begin
      for (int x = 0; x < dw; x++) begin
        case (em)
          2'b00:   v = src_px(x, y);
          2'b01:   v = src_px(x / 2, y / 2);
          2'b10:   v = (src_px(2*x, 2*y) + src_px(2*x+1, 2*y) +
                        src_px(2*x, 2*y+1) + src_px(2*x+1, 2*y+1)) / 4;
          default: v = src_px(2*x, 2*y);
        endcase
        e.addr = y * dw + x;
        e.data = v;
        sb.push_back(e);
        n++;
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_alu_done"}, 32'(bus.alu_done), 0);
    check_eq({tag, "_busy"},     32'(bus.busy),     0);
    check_eq({tag, "_dst_we"},   32'(bus.dst_we),   0);
    check_eq({tag, "_src_addr"}, 32'(bus.src_addr), 0);
    check_eq({tag, "_dst_addr"}, 32'(bus.dst_addr), 0);
    check_eq({tag, "_dst_data"}, 32'(bus.dst_data), 0);
  endtask

  task automatic run_frame(input logic [1:0] m, input int exp_cyc, input bit hold);
    int n, e0;
    bit got;
    push_expected(m, n);
    wr_cnt = 0;
    @(negedge clk);
    bus.mode      = m;
    bus.start_alu = 1'b1;
    e0            = edge_cnt + 1;
    @(negedge clk);
    check_eq("busy_after_start", 32'(bus.busy), 1);
    bus.mode = ~m;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.alu_done === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("done_seen", 32'(got), 1);
    if (got) begin
      check_eq("done_cycle", edge_cnt - e0 + 1, exp_cyc);
      check_eq("busy_at_done", 32'(bus.busy), 1);
    end
    if (!hold) bus.start_alu = 1'b0;
    @(negedge clk);
    check_eq("done_width", 32'(bus.alu_done), 0);
    check_eq("busy_after_done", 32'(bus.busy), 0);
    if (hold) begin
      @(negedge clk);
      check_eq("no_restart_hold", 32'(bus.busy), 0);
      bus.start_alu = 1'b0;
      @(negedge clk);
      check_eq("no_restart_idle", 32'(bus.busy), 0);
    end
    check_eq("write_count", wr_cnt, n);
    check_eq("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int n, avg_cyc;
    bit saw_done;
    rst_n         = 1'b0;
    bus.start_alu = 1'b0;
    bus.mode      = 2'b00;
`ifdef FRAME_ENGINE_AVG_EN
    avg_cyc = 19;
`else
    avg_cyc = 7;
`endif
    #5;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_frame(2'b00, 25, 1'b0);
    run_frame(2'b01, 97, 1'b0);
    run_frame(2'b10, avg_cyc, 1'b0);
    run_frame(2'b11, 7, 1'b1);
    run_frame(2'b00, 25, 1'b0);

    // abort after the third write
    push_expected(2'b00, n);
    wr_cnt = 0;
    @(negedge clk);
    bus.mode      = 2'b00;
    bus.start_alu = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (wr_cnt >= 3) break;
    end
    check_eq("abort_reach_3", wr_cnt, 3);
    @(negedge clk);
    bus.start_alu = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.alu_done === 1'b1) saw_done = 1'b1;
    end
    check_eq("abort_no_done", 32'(saw_done), 0);
    check_eq("abort_writes", wr_cnt, 3);
    check_eq("abort_idle_busy", 32'(bus.busy), 0);
    sb.delete();

    // reset mid-frame
    push_expected(2'b00, n);
    wr_cnt = 0;
    @(negedge clk);
    bus.start_alu = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    bus.start_alu = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(2'b00, 25, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/frame_engine.md
# frame_engine

Responder side of the control unit's `start_alu` / `alu_done` handshake. It executes one image-processing pass per request:
- reads a source frame from a synchronous read-only buffer;
- writes the transformed frame into the destination framebuffer;
- returns a one-cycle `alu_done` pulse to the control unit.

It sits between the control unit and the source and destination frame memories.

## Interface
Parameters:
- `SRC_W`, default 160: source width in pixels; must be even.
- `SRC_H`, default 120: source height in pixels; must be even.
- `PIX_W`, default 8: grayscale pixel width in bits.

Ports:
- `clk`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start_alu`  in  1: request level from the control unit.
- `mode`  in  2: `00` copy, `01` 2x replicate upscale, `10` 2x block-average downscale, `11` 2x decimate downscale.
- `alu_done`  out  1: one-cycle completion pulse.
- `busy`  out  1: high from the accepted start until `alu_done`, inclusive.
- `src_addr`  out  clog2(SRC_W·SRC_H): source read address; data returns one cycle later.
- `src_data`  in  PIX_W: source pixel.
- `dst_addr`  out  clog2(4·SRC_W·SRC_H): destination write address.
- `dst_data`  out  PIX_W: destination pixel.
- `dst_we`  out  1: destination write strobe.

## Operation
- Reset values: `alu_done`=0, `busy`=0, `dst_we`=0, `src_addr`=0, `dst_addr`=0, `dst_data`=0. State is IDLE.
- States:
  - IDLE: `start_alu`=1 latches `mode`, clears counters, and goes to FETCH.
  - FETCH: drives `src_addr`.
  - CAPTURE: samples `src_data` into the accumulator. It returns to FETCH while reads remain for the current pixel; otherwise it goes to WRITE.
  - WRITE: pulses `dst_we`. If this was the last pixel, go to DONE; otherwise advance `dx`/`dy` and go to FETCH.
  - DONE: pulses `alu_done` and goes to WAIT_LOW.
  - WAIT_LOW: stays until `start_alu`=0, then goes to IDLE.
- Destination geometry:
  - copy: `SRC_W`×`SRC_H`.
  - upscale: 2·`SRC_W`×2·`SRC_H`.
  - downscale: `SRC_W`/2×`SRC_H`/2.
- Scan order is row-major with `dx` fastest. `dst_addr` = `dy`·DST_W + `dx`.
- Source coordinates per destination pixel:
  - copy: (`dx`, `dy`).
  - upscale: (`dx`>>1, `dy`>>1).
  - decimate: (2`dx`, 2`dy`).
  - average: four reads in the order (2`dx`,2`dy`), (2`dx`+1,2`dy`), (2`dx`,2`dy`+1), (2`dx`+1,2`dy`+1).
- `src_addr` = `sy`·`SRC_W` + `sx`.
- Arithmetic:
  - The accumulator is `PIX_W`+2 bits wide. No overflow is possible.
  - Average output = sum>>2, truncated (no rounding).
  - All other modes pass the pixel unchanged.
- Abort: if `start_alu`=0 in any of FETCH, CAPTURE or WRITE, go to IDLE on the next edge. No `alu_done` is issued, and no further `dst_we` is asserted.
- `mode` changes after acceptance are ignored until the next accepted start.
- Reset asserted mid-frame: all outputs clear immediately, with no done pulse. The destination contents are left partial.

## Timing
- Reads per pixel R: 4 for average, 1 for every other mode. Cycles per pixel C = 2R+1, i.e. 3 or 9.
- Latency: with start sampled high in IDLE at edge 0, `alu_done` is high during cycle N_dst·C + 1, where N_dst is the destination pixel count.
- `dst_we` is high for exactly one cycle per destination pixel, and `dst_data` and `dst_addr` are valid in that same cycle.
- The `alu_done` pulse width is exactly 1 cycle.
- The control unit drops `start_alu` on the edge that samples `alu_done`. WAIT_LOW prevents the still-high `start_alu` from causing a spurious restart.
- Minimum gap from `alu_done` to the next accepted start is 2 cycles.

## Configuration
- Macro: `FRAME_ENGINE_AVG_EN`.
- Defined: mode `10` performs block averaging, with R=4 and C=9.
- Undefined: the accumulator adder and the 4-read sequencing are removed, and mode `10` behaves exactly as mode `11` (decimate, C=3).

## Structure
- Package `frame_engine_pkg` holds:
  - mode constants `MODE_COPY`, `MODE_UP`, `MODE_AVG`, `MODE_DEC`;
  - the state encoding;
  - `clog2`-based address-width constants.
- Sub-module `frame_addr_gen` holds the `dx`/`dy` counters, the sub-pixel read index, the last-pixel flag, and the `src_addr`/`dst_addr` computation. The FSM stays in `frame_engine`.

## Test plan
All scenarios use `SRC_W`=4, `SRC_H`=2, and a source memory holding value = address+10.
- Copy, `mode`=00: 8 writes with `dst_data` 10..17 at `dst_addr` 0..7; `alu_done` at cycle 25, one cycle wide.
- Upscale, `mode`=01: 32 writes. `dst_addr` 0,1,8,9 all hold 10; `dst_addr` 31 holds 17; `alu_done` at cycle 97.
- Average, `mode`=10 with `FRAME_ENGINE_AVG_EN`: source pixels (10,11,14,15) give 12 at `dst_addr` 0, and (12,13,16,17) give 14 at `dst_addr` 1; `alu_done` at cycle 19. Without the macro the result is 10 and 12, with `alu_done` at cycle 7.
- Handshake: `start_alu` held high for 1 cycle after `alu_done` causes no restart. A new start 2 cycles later is accepted.
- Abort and reset: `start_alu` dropped after the 3rd write gives no further `dst_we` and no `alu_done`. `rst_n` pulsed mid-frame gives all outputs 0 within the same cycle, and the next frame runs normally.
